// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared types and elaboration-time helpers for the SIFT octave pipeline
package sift_pkg;

    // Decimator input framing state
    typedef enum logic [0:0] {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } decim_state_e;

    // Ceiling log2; clog2(1) is 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bits needed to hold 0..value-1, never less than one bit
    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    // Output pixels per line; trailing partial windows are dropped
    function automatic int out_w(input int img_w, input int fx);
        return img_w / fx;
    endfunction

    // Output lines per frame; trailing partial windows are dropped
    function automatic int out_h(input int img_h, input int fy);
        return img_h / fy;
    endfunction

    // Window sum width: large enough that FX*FY full-scale pixels cannot overflow
    function automatic int sum_w(input int data_w, input int fx, input int fy);
        return data_w + clog2(fx * fy);
    endfunction

endpackage

// File: rtl/decim_line_acc.sv
// rtl/decim_line_acc.sv - per-output-column window sum store (built only with IMAGE_DECIMATOR_AVG_EN)
`ifdef IMAGE_DECIMATOR_AVG_EN
module decim_line_acc #(
    parameter int DEPTH  = 400,
    parameter int CH     = 1,
    parameter int SUM_W  = 10,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_clear,
    input  logic [CH*SUM_W-1:0]   i_add,
    output logic [CH*SUM_W-1:0]   o_sum
);

    logic [CH*SUM_W-1:0] r_mem [DEPTH];

    // Read-modify-write: the stored partial sum (or zero on a window's first row) plus the new row sum
    always_comb begin
        o_sum = '0;
        for (int c = 0; c < CH; c++) begin
            if (i_clear) begin
                o_sum[c*SUM_W +: SUM_W] = i_add[c*SUM_W +: SUM_W];
            end else begin
                o_sum[c*SUM_W +: SUM_W] = r_mem[i_addr][c*SUM_W +: SUM_W] + i_add[c*SUM_W +: SUM_W];
            end
        end
    end

    // Write the updated partial sum back; reset flushes every entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_addr] <= o_sum;
        end
    end

endmodule
`endif

// File: rtl/image_decimator.sv
// rtl/image_decimator.sv - FX x FY raster decimator, drop mode or box average under IMAGE_DECIMATOR_AVG_EN
module image_decimator
    import sift_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CH     = 1,
    parameter int IMG_W  = 800,
    parameter int IMG_H  = 600,
    parameter int FX     = 2,
    parameter int FY     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eol,
    input  logic                 out_ready,
    output logic                 resync_err
);

    localparam int BUS_W = CH * DATA_W;
    localparam int OUT_W = out_w(IMG_W, FX);
    localparam int OUT_H = out_h(IMG_H, FY);
    localparam int COL_W = width_of(IMG_W);
    localparam int ROW_W = width_of(IMG_H);
    localparam int CX_W  = width_of(FX);
    localparam int CY_W  = width_of(FY);
    localparam int OX_W  = width_of(OUT_W + 1);
    localparam int OY_W  = width_of(OUT_H + 1);

    if (FX < 1 || FY < 1) begin : g_factor_check
        $error("image_decimator: FX and FY must be at least 1");
    end

    decim_state_e r_state, w_state_nxt;

    // Raster position plus the position expressed as (window index, offset inside window)
    logic [COL_W-1:0] r_col, w_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row, w_row_nxt;
    logic [CX_W-1:0]  r_cx,  w_cx,  w_cx_nxt;
    logic [CY_W-1:0]  r_cy,  w_cy,  w_cy_nxt;
    logic [OX_W-1:0]  r_ox,  w_ox,  w_ox_nxt;
    logic [OY_W-1:0]  r_oy,  w_oy,  w_oy_nxt;

    logic             r_out_valid;
    logic [BUS_W-1:0] r_out_data;
    logic             r_out_sof;
    logic             r_out_eol;
    logic             r_resync_err;

    logic             w_in_ready;
    logic             w_xfer;
    logic             w_proc;
    logic             w_resync;
    logic             w_line_end;
    logic             w_frame_end;
    logic             w_in_win;
    logic             w_phase_hit;
    logic             w_emit;
    logic             w_out_sof_nxt;
    logic             w_out_eol_nxt;
    logic [BUS_W-1:0] w_out_data_nxt;

    // A held output beat stalls the input, whether or not the next beat would emit
    assign w_in_ready = !r_out_valid | out_ready;
    assign w_xfer     = in_valid & w_in_ready;
    // Before the first sof every beat is discarded; an sof beat is always taken as pixel (0,0)
    assign w_proc     = w_xfer & ((r_state == S_RUN) | in_sof);
    assign w_resync   = w_xfer & in_sof & (r_state == S_RUN) & ((r_col != '0) | (r_row != '0));

    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;
    assign w_cx  = in_sof ? '0 : r_cx;
    assign w_cy  = in_sof ? '0 : r_cy;
    assign w_ox  = in_sof ? '0 : r_ox;
    assign w_oy  = in_sof ? '0 : r_oy;

    assign w_line_end  = (w_col == COL_W'(IMG_W - 1));
    assign w_frame_end = (w_row == ROW_W'(IMG_H - 1));
    assign w_in_win    = (w_ox < OX_W'(OUT_W)) & (w_oy < OY_W'(OUT_H));

    assign w_out_sof_nxt = (w_ox == '0) & (w_oy == '0);
    assign w_out_eol_nxt = (w_ox == OX_W'(OUT_W - 1));
    assign w_emit        = w_proc & w_in_win & w_phase_hit;

    // Framing FSM: wait for the first sof, then run until reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC:  if (w_xfer && in_sof) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_SYNC;
        endcase
    end

    // Framing FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position advance: window offsets wrap at FX/FY, everything restarts at end of line / frame
    always_comb begin
        w_col_nxt = w_col + COL_W'(1);
        w_cx_nxt  = (w_cx == CX_W'(FX - 1)) ? '0 : w_cx + CX_W'(1);
        w_ox_nxt  = (w_cx == CX_W'(FX - 1)) ? w_ox + OX_W'(1) : w_ox;
        w_row_nxt = w_row;
        w_cy_nxt  = w_cy;
        w_oy_nxt  = w_oy;
        if (w_line_end) begin
            w_col_nxt = '0;
            w_cx_nxt  = '0;
            w_ox_nxt  = '0;
            if (w_frame_end) begin
                w_row_nxt = '0;
                w_cy_nxt  = '0;
                w_oy_nxt  = '0;
            end else begin
                w_row_nxt = w_row + ROW_W'(1);
                w_cy_nxt  = (w_cy == CY_W'(FY - 1)) ? '0 : w_cy + CY_W'(1);
                w_oy_nxt  = (w_cy == CY_W'(FY - 1)) ? w_oy + OY_W'(1) : w_oy;
            end
        end
    end

    // Position counters move only on processed beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_cx  <= '0;
            r_cy  <= '0;
            r_ox  <= '0;
            r_oy  <= '0;
        end else if (w_proc) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            r_cx  <= w_cx_nxt;
            r_cy  <= w_cy_nxt;
            r_ox  <= w_ox_nxt;
            r_oy  <= w_oy_nxt;
        end
    end

`ifdef IMAGE_DECIMATOR_AVG_EN
    localparam int SUM_W  = sum_w(DATA_W, FX, FY);
    localparam int SHIFT  = clog2(FX * FY);
    localparam int ADDR_W = width_of(OUT_W);

    if (((FX & (FX - 1)) != 0) || ((FY & (FY - 1)) != 0)) begin : g_avg_pow2_check
        $error("image_decimator: box average needs power-of-two FX and FY");
    end

    logic [CH*SUM_W-1:0] r_hsum;
    logic [CH*SUM_W-1:0] w_hsum_nxt;
    logic [CH*SUM_W-1:0] w_acc_sum;
    logic [BUS_W-1:0]    w_avg_data;
    logic                w_acc_en;
    logic                w_acc_wr;

    // Emit on the bottom-right pixel, once the whole window has been summed
    assign w_phase_hit = (w_cx == CX_W'(FX - 1)) & (w_cy == CY_W'(FY - 1));
    assign w_acc_en    = w_proc & w_in_win;
    assign w_acc_wr    = w_acc_en & (w_cx == CX_W'(FX - 1));

    // Horizontal run sum across the FX pixels of the current window row
    always_comb begin
        w_hsum_nxt = '0;
        for (int c = 0; c < CH; c++) begin
            if (w_cx == '0) begin
                w_hsum_nxt[c*SUM_W +: SUM_W] = SUM_W'(in_data[c*DATA_W +: DATA_W]);
            end else begin
                w_hsum_nxt[c*SUM_W +: SUM_W] = r_hsum[c*SUM_W +: SUM_W]
                                             + SUM_W'(in_data[c*DATA_W +: DATA_W]);
            end
        end
    end

    // Hold the horizontal run sum between pixels of a window row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsum <= '0;
        end else if (w_acc_en) begin
            r_hsum <= w_hsum_nxt;
        end
    end

    decim_line_acc #(
        .DEPTH  (OUT_W),
        .CH     (CH),
        .SUM_W  (SUM_W),
        .ADDR_W (ADDR_W)
    ) u_line_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (w_acc_wr),
        .i_addr  (ADDR_W'(w_ox)),
        .i_clear (w_cy == '0),
        .i_add   (w_hsum_nxt),
        .o_sum   (w_acc_sum)
    );

    // Mean of the window: truncating shift of the full window sum
    always_comb begin
        w_avg_data = '0;
        for (int c = 0; c < CH; c++) begin
            w_avg_data[c*DATA_W +: DATA_W] = DATA_W'(w_acc_sum[c*SUM_W +: SUM_W] >> SHIFT);
        end
    end

    assign w_out_data_nxt = w_avg_data;
`else
    // Emit the top-left pixel of each window, pass its data through unchanged
    assign w_phase_hit    = (w_cx == '0) & (w_cy == '0);
    assign w_out_data_nxt = in_data;
`endif

    // Output register: load on emit, otherwise hold until downstream takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_data_nxt;
            r_out_sof   <= w_out_sof_nxt;
            r_out_eol   <= w_out_eol_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // One-cycle pulse for an sof that arrives mid-frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resync_err <= 1'b0;
        end else begin
            r_resync_err <= w_resync;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sof    = r_out_sof;
    assign out_eol    = r_out_eol;
    assign resync_err = r_resync_err;

endmodule

// File: tb/tb_image_decimator.sv
// tb/tb_image_decimator.sv - self-checking bench for image_decimator, 8x4 and 7x4 frames, FX=FY=2
module tb_image_decimator;

    localparam int DW    = 8;
    localparam int IMG_H = 4;
    localparam int FX    = 2;
    localparam int FY    = 2;

`ifdef IMAGE_DECIMATOR_AVG_EN
    localparam int EXP8[8]    = '{4, 6, 8, 10, 20, 22, 24, 26};
    localparam int EXP7[6]    = '{4, 6, 8, 18, 20, 22};
    localparam int FIRST_SYNC = 114;
    localparam int RESYNC_IDX = 1;
    localparam int RESYNC_VAL = 204;
`else
    localparam int EXP8[8]    = '{0, 2, 4, 6, 16, 18, 20, 22};
    localparam int EXP7[6]    = '{0, 2, 4, 14, 16, 18};
    localparam int FIRST_SYNC = 110;
    localparam int RESYNC_IDX = 4;
    localparam int RESYNC_VAL = 200;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data    [2];
    logic          in_valid   [2];
    logic          in_sof     [2];
    logic          in_ready   [2];
    logic [DW-1:0] out_data   [2];
    logic          out_valid  [2];
    logic          out_sof    [2];
    logic          out_eol    [2];
    logic          out_ready  [2];
    logic          resync_err [2];

    always #5 clk = ~clk;

    image_decimator #(.DATA_W(DW), .CH(1), .IMG_W(8), .IMG_H(IMG_H), .FX(FX), .FY(FY)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_sof(in_sof[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_sof(out_sof[0]), .out_eol(out_eol[0]),
        .out_ready(out_ready[0]), .resync_err(resync_err[0])
    );

    image_decimator #(.DATA_W(DW), .CH(1), .IMG_W(7), .IMG_H(IMG_H), .FX(FX), .FY(FY)) u_dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_sof(in_sof[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_sof(out_sof[1]), .out_eol(out_eol[1]),
        .out_ready(out_ready[1]), .resync_err(resync_err[1])
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 0;

    // Reference model state: expected output register contents and frame position
    int m_col [2];
    int m_row [2];
    bit m_sync [2];
    bit m_valid [2];
    int m_data [2];
    bit m_sof [2];
    bit m_eol [2];
    bit m_rs [2];
    int pix [2][IMG_H][8];

    // Observed output transfers
    int lg_data [2][64];
    bit lg_sof  [2][64];
    bit lg_eol  [2][64];
    int lg_n    [2];
    int rs_cnt  [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int img_w(input int d);
        return (d == 0) ? 8 : 7;
    endfunction

    task automatic model_reset(input int d);
        m_col[d] = 0; m_row[d] = 0; m_sync[d] = 0;
        m_valid[d] = 0; m_data[d] = 0; m_sof[d] = 0; m_eol[d] = 0; m_rs[d] = 0;
    endtask

    // Decide what the upcoming clock edge does, from frame position and window rules
    task automatic model_step(input int d);
        bit rdy;
        bit emit;
        int c, r, v, ow, oh;
        rdy  = !m_valid[d] || out_ready[d];
        emit = 0;
        v    = 0;
        m_rs[d] = 0;
        if (m_valid[d] && out_ready[d]) m_valid[d] = 0;
        if (in_valid[d] && rdy) begin
            if (in_sof[d]) begin
                if (m_sync[d] && (m_col[d] != 0 || m_row[d] != 0)) m_rs[d] = 1;
                m_col[d] = 0; m_row[d] = 0; m_sync[d] = 1;
            end
            if (m_sync[d]) begin
                c  = m_col[d];
                r  = m_row[d];
                ow = img_w(d) / FX;
                oh = IMG_H / FY;
                pix[d][r][c] = int'(in_data[d]);
                if (c / FX < ow && r / FY < oh) begin
`ifdef IMAGE_DECIMATOR_AVG_EN
                    if (c % FX == FX - 1 && r % FY == FY - 1) begin
                        emit = 1;
                        for (int j = 0; j < FY; j++)
                            for (int i = 0; i < FX; i++)
                                v += pix[d][r - j][c - i];
                        v = v / (FX * FY);
                    end
`else
                    if (c % FX == 0 && r % FY == 0) begin
                        emit = 1;
                        v = pix[d][r][c];
                    end
`endif
                end
                if (emit) begin
                    m_valid[d] = 1;
                    m_data[d]  = v;
                    m_sof[d]   = (c / FX == 0) && (r / FY == 0);
                    m_eol[d]   = (c / FX == ow - 1);
                end
                m_col[d]++;
                if (m_col[d] == img_w(d)) begin
                    m_col[d] = 0;
                    m_row[d]++;
                    if (m_row[d] == IMG_H) m_row[d] = 0;
                end
            end
        end
    endtask

    // Compare every cycle on the falling edge, then advance the model for the next rising edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_on) begin
                chk($sformatf("d%0d out_valid", d), int'(out_valid[d]), int'(m_valid[d]));
                chk($sformatf("d%0d in_ready", d), int'(in_ready[d]), int'(!m_valid[d] || out_ready[d]));
                chk($sformatf("d%0d resync_err", d), int'(resync_err[d]), int'(m_rs[d]));
                if (m_valid[d]) begin
                    chk($sformatf("d%0d out_data", d), int'(out_data[d]), m_data[d]);
                    chk($sformatf("d%0d out_sof", d), int'(out_sof[d]), int'(m_sof[d]));
                    chk($sformatf("d%0d out_eol", d), int'(out_eol[d]), int'(m_eol[d]));
                end
                if (out_valid[d] && out_ready[d] && lg_n[d] < 64) begin
                    lg_data[d][lg_n[d]] = int'(out_data[d]);
                    lg_sof[d][lg_n[d]]  = out_sof[d];
                    lg_eol[d][lg_n[d]]  = out_eol[d];
                    lg_n[d]++;
                end
                if (resync_err[d]) rs_cnt[d]++;
            end
            if (!rst_n) model_reset(d);
            else model_step(d);
        end
    end

    task automatic send(input int d, input int data, input bit sof);
        int t;
        in_data[d]  = DW'(data);
        in_sof[d]   = sof;
        in_valid[d] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            t++;
            if (t > 200) begin
                n_tot++;
                $display("FAIL d%0d send timeout: in_ready stuck at 0, expected 1", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_sof[d]   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int t;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_data[d] = '0; in_valid[d] = 0; in_sof[d] = 0; out_ready[d] = 1;
            lg_n[d] = 0; rs_cnt[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1;

        // Reset state
        @(negedge clk);
        chk("reset out_valid", int'(out_valid[0]), 0);
        chk("reset out_data", int'(out_data[0]), 0);
        chk("reset out_sof", int'(out_sof[0]), 0);
        chk("reset out_eol", int'(out_eol[0]), 0);
        chk("reset resync_err", int'(resync_err[0]), 0);
        chk("reset in_ready", int'(in_ready[0]), 1);
        @(posedge clk);
        #1;

        // 8x4 ramp, free-running output
        lg_n[0] = 0;
        for (int i = 0; i < 32; i++) send(0, i, i == 0);
        idle(4);
        chk("ramp count", lg_n[0], 8);
        for (int k = 0; k < 8; k++) chk($sformatf("ramp out[%0d]", k), lg_data[0][k], EXP8[k]);
        chk("ramp sof[0]", int'(lg_sof[0][0]), 1);
        chk("ramp sof[1]", int'(lg_sof[0][1]), 0);
        chk("ramp eol[0]", int'(lg_eol[0][0]), 0);
        chk("ramp eol[3]", int'(lg_eol[0][3]), 1);
        chk("ramp eol[7]", int'(lg_eol[0][7]), 1);

        // Same frame with downstream stalled after the first output
        lg_n[0] = 0;
        out_ready[0] = 0;
        fork
            begin
                for (int i = 0; i < 32; i++) send(0, i, i == 0);
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid[0] && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("stall first output seen", int'(out_valid[0]), 1);
                held = int'(out_data[0]);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall data stable", int'(out_data[0]), held);
                    chk("stall in_ready low", int'(in_ready[0]), 0);
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1;
            end
        join
        idle(4);
        chk("stall count", lg_n[0], 8);
        for (int k = 0; k < 8; k++) chk($sformatf("stall out[%0d]", k), lg_data[0][k], EXP8[k]);

        // Reset while an output beat is held
        out_ready[0] = 0;
        send(0, 50, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset out_valid", int'(out_valid[0]), 0);
        chk("midreset out_data", int'(out_data[0]), 0);
        @(posedge clk);
        #1;
        out_ready[0] = 1;

        // No sof after reset: everything discarded until sof at beat 10
        lg_n[0] = 0;
        for (int i = 0; i < 10; i++) send(0, 100 + i, 0);
        idle(3);
        chk("no-sof outputs", lg_n[0], 0);
        send(0, 110, 1);
        for (int i = 1; i < 32; i++) send(0, 110 + i, 0);
        idle(4);
        chk("sync count", lg_n[0], 8);
        chk("sync first data", lg_data[0][0], FIRST_SYNC);
        chk("sync first sof", int'(lg_sof[0][0]), 1);
        chk("no resync so far", rs_cnt[0], 0);

        // sof injected at (col=3,row=1)
        lg_n[0] = 0;
        rs_cnt[0] = 0;
        for (int i = 0; i < 11; i++) send(0, i, i == 0);
        send(0, 200, 1);
        for (int i = 1; i < 32; i++) send(0, 200 + i, 0);
        idle(4);
        chk("resync pulse cycles", rs_cnt[0], 1);
        chk("resync count", lg_n[0], RESYNC_IDX + 8);
        chk("resync next data", lg_data[0][RESYNC_IDX], RESYNC_VAL);
        chk("resync next sof", int'(lg_sof[0][RESYNC_IDX]), 1);

        // 7-wide frame: trailing column dropped
        lg_n[1] = 0;
        for (int i = 0; i < 28; i++) send(1, i, i == 0);
        idle(4);
        chk("w7 count", lg_n[1], 6);
        for (int k = 0; k < 6; k++) chk($sformatf("w7 out[%0d]", k), lg_data[1][k], EXP7[k]);
        chk("w7 eol[2]", int'(lg_eol[1][2]), 1);
        chk("w7 eol[5]", int'(lg_eol[1][5]), 1);
        chk("w7 sof[3]", int'(lg_sof[1][3]), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
